// File: rtl/sponge_pkg.sv
// rtl/sponge_pkg.sv - shared types, default widths and helpers for the sponge datapath
package sponge_pkg;

  // Default state and round-count widths shared with the absorb/squeeze sequencers
  localparam int SPONGE_SWIDTH  = 320;
  localparam int SPONGE_RCWIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } perm_arb_state_t;

  // Next round-robin position after idx among n requesters
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sponge_perm_arbiter_if.sv
// rtl/sponge_perm_arbiter_if.sv - requester and permutation-core signal bundle for the arbiter
interface sponge_perm_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int SWIDTH  = sponge_pkg::SPONGE_SWIDTH,
  parameter int RCWIDTH = sponge_pkg::SPONGE_RCWIDTH
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*SWIDTH-1:0]  req_state;
  logic [NREQ*RCWIDTH-1:0] req_rounds;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [SWIDTH-1:0]       rsp_state;
  logic                    rsp_err;
  logic                    perm_start;
  logic [SWIDTH-1:0]       perm_state_in;
  logic [RCWIDTH-1:0]      perm_rounds;
  logic                    perm_done;
  logic [SWIDTH-1:0]       perm_state_out;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;

  // Requesters plus permutation core: everything the arbiter listens to
  modport master (
    output req_valid, req_state, req_rounds, rsp_ready, perm_done, perm_state_out,
    input  req_ready, rsp_valid, rsp_state, rsp_err, perm_start, perm_state_in,
    input  perm_rounds, busy, grant_id
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_state, req_rounds, rsp_ready, perm_done, perm_state_out,
    output req_ready, rsp_valid, rsp_state, rsp_err, perm_start, perm_state_in,
    output perm_rounds, busy, grant_id
  );

endinterface

// File: rtl/sponge_perm_arbiter_rr_picker.sv
// rtl/sponge_perm_arbiter_rr_picker.sv - combinational round-robin search starting at a pointer
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  localparam int SW1 = IW + 1;

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Walk from ptr_i upward, wrapping at NREQ; the first set bit wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + SW1'(k);
      if (sum >= SW1'(NREQ)) begin
        sum = sum - SW1'(NREQ);
      end
      pos = sum[IW-1:0];
      if (!any_o && valid_i[pos]) begin
        any_o        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/sponge_perm_arbiter.sv
// rtl/sponge_perm_arbiter.sv - round-robin sharing of one permutation core; PERM_TIMEOUT_EN adds a watchdog
module sponge_perm_arbiter
  import sponge_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int SWIDTH  = SPONGE_SWIDTH,
  parameter int RCWIDTH = SPONGE_RCWIDTH
`ifdef PERM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input logic                  clk,
  input logic                  reset,
  sponge_perm_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  perm_arb_state_t    state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q;
  logic [SWIDTH-1:0]  in_state_q;
  logic [SWIDTH-1:0]  result_q;
  logic [RCWIDTH-1:0] rounds_q;

  logic [NREQ-1:0]    pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [SWIDTH-1:0]  sel_state;
  logic [RCWIDTH-1:0] sel_rounds;
  logic               accept;
  logic               timeout_hit;
  logic               rsp_err_w;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept = (state_q == IDLE) && pick_any;

  // Select the winning requester's state and round count
  always_comb begin
    sel_state  = '0;
    sel_rounds = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_state  = bus.req_state[i*SWIDTH +: SWIDTH];
        sel_rounds = bus.req_rounds[i*RCWIDTH +: RCWIDTH];
      end
    end
  end

  // State register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: zero rounds bypass the core, pointer advances past the owner on response handshake
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = (sel_rounds == '0) ? RESP : START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.perm_done || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IW'(rr_next(int'(grant_q), NREQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches; the result starts as the input so bypass and timeout return it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= '0;
      in_state_q <= '0;
      rounds_q   <= '0;
      result_q   <= '0;
    end else if (accept) begin
      grant_q    <= pick_idx;
      in_state_q <= sel_state;
      rounds_q   <= sel_rounds;
      result_q   <= sel_state;
    end else if ((state_q == WAIT) && bus.perm_done) begin
      result_q   <= bus.perm_state_out;
    end
  end

`ifdef PERM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == WAIT) && !bus.perm_done && (cnt_q == CW'(TIMEOUT - 1));
  assign rsp_err_w   = (state_q == RESP) && err_q;

  // Watchdog counts WAIT cycles; reaching TIMEOUT flags the response as an error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_w   = 1'b0;
`endif

  // Outputs decoded from state; req_ready is held off while reset is asserted
  always_comb begin
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.rsp_state     = '0;
    bus.rsp_err       = rsp_err_w;
    bus.perm_start    = (state_q == START);
    bus.perm_state_in = in_state_q;
    bus.perm_rounds   = rounds_q;
    bus.busy          = (state_q != IDLE);
    bus.grant_id      = grant_q;
    if ((state_q == IDLE) && !reset) begin
      bus.req_ready = pick_grant;
    end
    if (state_q == RESP) begin
      bus.rsp_state = result_q;
      for (int i = 0; i < NREQ; i++) begin
        bus.rsp_valid[i] = (grant_q == IW'(i));
      end
    end
  end

endmodule

// File: tb/tb_sponge_perm_arbiter.sv
// tb/tb_sponge_perm_arbiter.sv - scoreboard bench for sponge_perm_arbiter with a model permutation core
module tb_sponge_perm_arbiter;

  localparam int NR = 2;
  localparam int SW = 320;
  localparam int RW = 4;
  localparam logic [SW-1:0] MASK = {40{8'hA5}};

  typedef struct {
    int          idx;
    logic [SW-1:0] st;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    int          idx;
    logic [SW-1:0] st;
    int          rounds;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   core_mute = 1'b0;
  int   start_cnt = 0;
  int   start_cyc = -1;

  sponge_perm_arbiter_if #(.NREQ(NR), .SWIDTH(SW), .RCWIDTH(RW)) bus ();

  sponge_perm_arbiter #(
    .NREQ(NR), .SWIDTH(SW), .RCWIDTH(RW)
`ifdef PERM_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic note_accept(input int idx, input logic [SW-1:0] st, input int rounds, input int lat);
    exp_t e;
    e.idx = idx;
    e.st  = (rounds == 0) ? st : (st ^ MASK);
    e.err = 1'b0;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_accept(input int idx, output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready[idx] === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d never saw req_ready", idx);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic drive_req(input int idx, input logic [SW-1:0] st, input int rounds);
    bus.req_valid[idx]               = 1'b1;
    bus.req_state[idx*SW +: SW]      = st;
    bus.req_rounds[idx*RW +: RW]     = RW'(rounds);
  endtask

  task automatic run_txn(input int idx, input logic [SW-1:0] st, input int rounds, input int lat);
    int acc;
    bit ok;
    int sc0;
    @(posedge clk); #1;
    drive_req(idx, st, rounds);
    sc0 = start_cnt;
    wait_accept(idx, acc, ok);
    if (ok) note_accept(idx, st, rounds, lat);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    if (ok) begin
      chk("grant_id", bus.grant_id, idx);
      chk("busy_after_accept", bus.busy, 1);
    end
    drain(rounds + 30);
    chk("perm_start_count", start_cnt - sc0, (rounds != 0) ? 1 : 0);
    if (ok && rounds != 0) chk("perm_start_cycle", start_cyc, acc + 1);
  endtask

  task automatic contend(input int first, input int second);
    int            order[$];
    bit [NR-1:0]   pend;
    logic [SW-1:0] st[NR];
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      st[i] = SW'(64'hC0DE_0000_0000_0000) + SW'(i * 32'h1111);
      drive_req(i, st[i], 2 + i);
    end
    pend = '1;
    for (int t = 0; t < 200 && pend != 0; t++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] === 1'b1 && pend[i]) begin
          order.push_back(i);
          note_accept(i, st[i], 2 + i, 2 + i + 3);
          pend[i] = 1'b0;
        end
      end
      @(posedge clk); #1;
      bus.req_valid = pend;
    end
    drain(100);
    chk("order_len", order.size(), 2);
    if (order.size() == 2) begin
      chk("order_first", order[0], first);
      chk("order_second", order[1], second);
    end
  endtask

  // Model core: result = state ^ A5.., done pulsed rounds+1 cycles after perm_start
  initial begin
    logic [SW-1:0] cap;
    int            rnd;
    bit            aborted;
    bus.perm_done      = 1'b0;
    bus.perm_state_out = '0;
    forever begin
      @(negedge clk);
      if (bus.perm_start === 1'b1) begin
        cap       = bus.perm_state_in;
        rnd       = int'(bus.perm_rounds);
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
        aborted   = 1'b0;
        for (int c = 0; c < rnd + 1; c++) begin
          @(posedge clk);
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted && !core_mute) begin
          #1;
          chk("perm_in_stable", bus.perm_state_in, cap);
          bus.perm_done      = 1'b1;
          bus.perm_state_out = cap ^ MASK;
          @(posedge clk); #1;
          bus.perm_done      = 1'b0;
          bus.perm_state_out = '0;
        end
      end
    end
  end

  // Response monitor: compare at the first cycle of each rsp_valid
  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((|bus.rsp_valid) && !prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing expected", bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          chk("rsp_onehot", bus.rsp_valid, 1 << e.idx);
          chk("rsp_state", bus.rsp_state, e.st);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_latency", cyc, e.due);
        end
      end
      prev = |bus.rsp_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[5];
    logic [SW-1:0] bst;
    logic [SW-1:0] st1;
    int            acc;
    bit            ok;
    bit            seen;

    tbl[0] = '{idx: 0, st: SW'(32'h1234), rounds: 10, lat: 13};
    tbl[1] = '{idx: 1, st: SW'(32'hFFFF), rounds: 0, lat: 1};
    tbl[2] = '{idx: 0, st: {10{32'hDEADBEEF}}, rounds: 1, lat: 4};
    tbl[3] = '{idx: 1, st: {5{64'h0123456789ABCDEF}}, rounds: 15, lat: 18};
    tbl[4] = '{idx: 0, st: '0, rounds: 0, lat: 1};

    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_state  = '0;
    bus.req_rounds = '0;
    bus.rsp_ready  = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_state", bus.rsp_state, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_perm_start", bus.perm_start, 0);
    chk("rst_perm_state_in", bus.perm_state_in, 0);
    chk("rst_perm_rounds", bus.perm_rounds, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    reset = 1'b0;

    // Contention from reset, then again with the pointer advanced past 0
    contend(0, 1);
    run_txn(0, SW'(32'h0BAD_F00D), 3, 6);
    contend(1, 0);

    // Table of single transactions
    for (int v = 0; v < 5; v++) begin
      run_txn(tbl[v].idx, tbl[v].st, tbl[v].rounds, tbl[v].lat);
    end

    // Response backpressure on requester 0; rsp_ready[1] high must be ignored
    bst = SW'(64'h5555_AAAA_1234_5678);
    st1 = SW'(32'h7777_0001);
    @(posedge clk); #1;
    bus.rsp_ready = 2'b10;
    drive_req(0, bst, 3);
    wait_accept(0, acc, ok);
    if (ok) note_accept(0, bst, 3, 6);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.rsp_valid[0] === 1'b1);
    end
    chk("bp_rsp_seen", seen, 1);
    @(posedge clk); #1;
    drive_req(1, st1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid_hold", bus.rsp_valid, 2'b01);
      chk("bp_rsp_state_hold", bus.rsp_state, bst ^ MASK);
      chk("bp_no_grant", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_handshake_cycle", bus.rsp_valid, 2'b01);
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_grant", bus.req_ready, 2'b10);
    if (bus.req_ready[1] === 1'b1) note_accept(1, st1, 0, 1);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    drain(20);

    // Leave the pointer at 1, then reset in the middle of a WAIT
    run_txn(0, SW'(32'h0000_C0C0), 2, 5);
    @(posedge clk); #1;
    drive_req(0, SW'(32'h0ABC_DEF0), 10);
    wait_accept(0, acc, ok);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.perm_start === 1'b1);
    end
    chk("rw_start_seen", seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rw_busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("rw_rsp_valid", bus.rsp_valid, 0);
    chk("rw_perm_start", bus.perm_start, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_grant_id", bus.grant_id, 0);
    chk("rw_perm_state_in", bus.perm_state_in, 0);
    chk("rw_rsp_state", bus.rsp_state, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    contend(0, 1);

`ifdef PERM_TIMEOUT_EN
    // Core never answers: watchdog returns the original state with rsp_err
    core_mute = 1'b1;
    @(posedge clk); #1;
    drive_req(0, SW'(32'h7E57_0042), 5);
    wait_accept(0, acc, ok);
    if (ok) begin
      exp_t e;
      e.idx = 0;
      e.st  = SW'(32'h7E57_0042);
      e.err = 1'b1;
      e.due = acc + 22;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    drain(80);
    core_mute = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
